// File: rtl/rename_pkg.sv
// Shared types and constants for the quad-wide rename stage.
package rename_pkg;
  localparam int unsigned WIDTH     = 4;
  localparam int unsigned ARCH_BITS = 5;
  localparam int unsigned PHYS_BITS = 6;
  localparam int unsigned ARCH_REGS = 32;

  typedef logic [ARCH_BITS-1:0] arch_tag_t;
  typedef logic [PHYS_BITS-1:0] phys_tag_t;
  typedef phys_tag_t [ARCH_REGS-1:0] map_t;

  function automatic map_t identity_map();
    map_t m;
    for (int unsigned r = 0; r < ARCH_REGS; r++) m[r] = phys_tag_t'(r);
    return m;
  endfunction
endpackage

// File: rtl/rename_group_bypass.sv
// Slot-priority match: finds the highest older slot (j < slot) writing the lookup arch reg.
module rename_group_bypass
  import rename_pkg::*;
(
  input  arch_tag_t [WIDTH-1:0] dest_arch,
  input  logic      [WIDTH-1:0] mask,
  input  phys_tag_t [WIDTH-1:0] new_tags,
  input  arch_tag_t             lookup,
  input  logic      [1:0]       slot,
  output logic                  hit,
  output phys_tag_t             tag
);
  always_comb begin
    hit = 1'b0;
    tag = '0;
    for (int unsigned j = 0; j < WIDTH; j++) begin
      if (j < 32'(slot) && mask[j] && dest_arch[j] == lookup) begin
        hit = 1'b1;
        tag = new_tags[j];
      end
    end
  end
endmodule

// File: rtl/rename_map_quad.sv
// 4-wide rename stage with speculative/committed maps, intra-group bypass and commit freeing.
// Optional: RENAME_R0_FIXED_EN pins arch r0 to phys 0 and never renames it.
module rename_map_quad
  import rename_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          rewind,
  input  logic                          rename_valid,
  input  logic [WIDTH-1:0]              rename_mask,
  input  logic [WIDTH*ARCH_BITS-1:0]    dest_arch,
  input  logic [2*WIDTH*ARCH_BITS-1:0]  src_arch,
  output logic [WIDTH-1:0]              take,
  output logic                          enable_take,
  input  logic [WIDTH*PHYS_BITS-1:0]    new_phys,
  output logic                          out_valid,
  output logic [WIDTH*PHYS_BITS-1:0]    out_dest_phys,
  output logic [WIDTH*PHYS_BITS-1:0]    out_old_phys,
  output logic [2*WIDTH*PHYS_BITS-1:0]  out_src_phys,
  input  logic                          commit_valid,
  input  logic [WIDTH-1:0]              commit_mask,
  input  logic [WIDTH*ARCH_BITS-1:0]    commit_dest_arch,
  input  logic [WIDTH*PHYS_BITS-1:0]    commit_phys,
  output logic [WIDTH-1:0]              put,
  output logic                          enable_put,
  output logic [WIDTH*PHYS_BITS-1:0]    write_put
);
`ifdef RENAME_R0_FIXED_EN
  localparam bit R0_FIXED = 1'b1;
`else
  localparam bit R0_FIXED = 1'b0;
`endif

  arch_tag_t [WIDTH-1:0]   in_dest, c_dest;
  arch_tag_t [2*WIDTH-1:0] in_src;
  phys_tag_t [WIDTH-1:0]   tags_in, c_phys;
  assign in_dest = dest_arch;
  assign in_src  = src_arch;
  assign tags_in = new_phys;
  assign c_dest  = commit_dest_arch;
  assign c_phys  = commit_phys;

  logic                    s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]        s1_mask_q, s1_mask_d;
  arch_tag_t [WIDTH-1:0]   s1_dest_q, s1_dest_d;
  arch_tag_t [2*WIDTH-1:0] s1_src_q, s1_src_d;
  map_t                    spec_map_q, spec_map_d, commit_map_q, commit_map_d;
  logic                    out_valid_q, out_valid_d;
  phys_tag_t [WIDTH-1:0]   out_dest_q, out_dest_d, out_old_q, out_old_d;
  phys_tag_t [2*WIDTH-1:0] out_src_q, out_src_d;
  logic [WIDTH-1:0]        put_q, put_d;
  logic                    enable_put_q, enable_put_d;
  phys_tag_t [WIDTH-1:0]   write_put_q, write_put_d;

  // Dest r0 behaves as a masked slot when r0 is pinned.
  logic [WIDTH-1:0] eff_mask, c_mask_eff;
  always_comb begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      eff_mask[i]   = s1_mask_q[i]   && !(R0_FIXED && s1_dest_q[i] == '0);
      c_mask_eff[i] = commit_mask[i] && !(R0_FIXED && c_dest[i] == '0);
    end
  end

  logic [WIDTH-1:0]        dest_hit, c_hit;
  phys_tag_t [WIDTH-1:0]   dest_byp, c_byp;
  logic [2*WIDTH-1:0]      src_hit;
  phys_tag_t [2*WIDTH-1:0] src_byp;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slot
    rename_group_bypass u_dest (
      .dest_arch(s1_dest_q), .mask(eff_mask), .new_tags(tags_in),
      .lookup(s1_dest_q[i]), .slot(2'(i)), .hit(dest_hit[i]), .tag(dest_byp[i])
    );
    rename_group_bypass u_commit (
      .dest_arch(c_dest), .mask(c_mask_eff), .new_tags(c_phys),
      .lookup(c_dest[i]), .slot(2'(i)), .hit(c_hit[i]), .tag(c_byp[i])
    );
    for (genvar k = 0; k < 2; k++) begin : g_src
      rename_group_bypass u_src (
        .dest_arch(s1_dest_q), .mask(eff_mask), .new_tags(tags_in),
        .lookup(s1_src_q[2*i+k]), .slot(2'(i)),
        .hit(src_hit[2*i+k]), .tag(src_byp[2*i+k])
      );
    end
  end

  phys_tag_t [WIDTH-1:0]   ren_dest, ren_old, free_tags;
  phys_tag_t [2*WIDTH-1:0] ren_src;
  map_t                    spec_wr, commit_wr;

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_mask_d    = s1_mask_q;
    s1_dest_d    = s1_dest_q;
    s1_src_d     = s1_src_q;
    spec_map_d   = spec_map_q;
    commit_map_d = commit_map_q;
    out_valid_d  = out_valid_q;
    out_dest_d   = out_dest_q;
    out_old_d    = out_old_q;
    out_src_d    = out_src_q;
    put_d        = put_q;
    enable_put_d = enable_put_q;
    write_put_d  = write_put_q;

    spec_wr   = spec_map_q;
    commit_wr = commit_map_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      ren_dest[i]  = eff_mask[i] ? tags_in[i] : '0;
      ren_old[i]   = !eff_mask[i] ? '0 : dest_hit[i] ? dest_byp[i] : spec_map_q[s1_dest_q[i]];
      free_tags[i] = !c_mask_eff[i] ? '0 : c_hit[i] ? c_byp[i] : commit_map_q[c_dest[i]];
    end
    for (int unsigned s = 0; s < 2*WIDTH; s++) begin
      ren_src[s] = (R0_FIXED && s1_src_q[s] == '0) ? '0 :
                   src_hit[s] ? src_byp[s] : spec_map_q[s1_src_q[s]];
    end
    // Ascending slot order so the highest writing slot lands in the map.
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (eff_mask[i])   spec_wr[s1_dest_q[i]] = tags_in[i];
      if (c_mask_eff[i]) commit_wr[c_dest[i]]  = c_phys[i];
    end

    if (en) begin
      s1_valid_d  = rename_valid & ~rewind;
      s1_mask_d   = rename_mask;
      s1_dest_d   = in_dest;
      s1_src_d    = in_src;
      out_valid_d = s1_valid_q & ~rewind;
      out_dest_d  = out_valid_d ? ren_dest : '0;
      out_old_d   = out_valid_d ? ren_old  : '0;
      out_src_d   = out_valid_d ? ren_src  : '0;
      enable_put_d = commit_valid;
      put_d        = commit_valid ? c_mask_eff : '0;
      write_put_d  = commit_valid ? free_tags  : '0;
      if (commit_valid) commit_map_d = commit_wr;
      // Rewind copies the post-commit committed map and discards this cycle's rename write.
      if (rewind)          spec_map_d = commit_map_d;
      else if (s1_valid_q) spec_map_d = spec_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_q   <= 1'b0;
      s1_mask_q    <= '0;
      s1_dest_q    <= '0;
      s1_src_q     <= '0;
      spec_map_q   <= identity_map();
      commit_map_q <= identity_map();
      out_valid_q  <= 1'b0;
      out_dest_q   <= '0;
      out_old_q    <= '0;
      out_src_q    <= '0;
      put_q        <= '0;
      enable_put_q <= 1'b0;
      write_put_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_mask_q    <= s1_mask_d;
      s1_dest_q    <= s1_dest_d;
      s1_src_q     <= s1_src_d;
      spec_map_q   <= spec_map_d;
      commit_map_q <= commit_map_d;
      out_valid_q  <= out_valid_d;
      out_dest_q   <= out_dest_d;
      out_old_q    <= out_old_d;
      out_src_q    <= out_src_d;
      put_q        <= put_d;
      enable_put_q <= enable_put_d;
      write_put_q  <= write_put_d;
    end
  end

  assign take          = '1;
  assign enable_take   = en & rename_valid & ~rewind;
  assign out_valid     = out_valid_q;
  assign out_dest_phys = out_dest_q;
  assign out_old_phys  = out_old_q;
  assign out_src_phys  = out_src_q;
  assign put           = put_q;
  assign enable_put    = enable_put_q;
  assign write_put     = write_put_q;
endmodule

// File: tb/tb_rename_map_quad.sv
// Scoreboard bench for rename_map_quad: sequential per-slot reference model, decoupled monitor.
module tb_rename_map_quad;
`ifdef RENAME_R0_FIXED_EN
  localparam bit R0 = 1'b1;
`else
  localparam bit R0 = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, en, rewind, rename_valid, commit_valid;
  logic [3:0]  rename_mask, commit_mask, take, put;
  logic [19:0] dest_arch, commit_dest_arch;
  logic [39:0] src_arch;
  logic        enable_take, out_valid, enable_put;
  logic [23:0] new_phys, out_dest_phys, out_old_phys, commit_phys, write_put;
  logic [47:0] out_src_phys;

  rename_map_quad dut (
    .clk(clk), .reset(reset), .en(en), .rewind(rewind),
    .rename_valid(rename_valid), .rename_mask(rename_mask),
    .dest_arch(dest_arch), .src_arch(src_arch),
    .take(take), .enable_take(enable_take), .new_phys(new_phys),
    .out_valid(out_valid), .out_dest_phys(out_dest_phys),
    .out_old_phys(out_old_phys), .out_src_phys(out_src_phys),
    .commit_valid(commit_valid), .commit_mask(commit_mask),
    .commit_dest_arch(commit_dest_arch), .commit_phys(commit_phys),
    .put(put), .enable_put(enable_put), .write_put(write_put)
  );

  always #5 clk = ~clk;

  typedef struct { logic v; logic [23:0] d; logic [23:0] o; logic [47:0] s; } ren_exp_t;
  typedef struct { logic v; logic [3:0] p; logic [23:0] w; } com_exp_t;
  ren_exp_t ren_q[$];
  com_exp_t com_q[$];
  int unsigned vectors = 0, miscompares = 0;

  // Stimulus for the next edge.
  logic       r_reset, r_en, r_rewind, r_rv, r_cv;
  logic [3:0] r_mask, r_cmask;
  logic [4:0] r_dest[4], r_src[8], r_cdest[4];
  logic [5:0] r_cphys[4];

  // Reference state: two maps and the group waiting for its tags.
  logic [5:0] mspec[32], mcomm[32];
  logic       infl_v;
  logic [3:0] infl_mask;
  logic [4:0] infl_dest[4], infl_src[8];
  logic [5:0] infl_tags[4];
  int unsigned tag_ctr = 0;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit writes(input logic m, input logic [4:0] a);
    return m && !(R0 && a == 5'd0);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      mspec[r] = 6'(r);
      mcomm[r] = 6'(r);
    end
    infl_v = 1'b0;
    ren_q.delete();
    com_q.delete();
  endtask

  task automatic model_cycle();
    com_exp_t ce;
    ren_exp_t re;
    logic [5:0] tmp[32];
    ce.v = r_cv; ce.p = '0; ce.w = '0;
    if (r_cv) begin
      tmp = mcomm;
      for (int i = 0; i < 4; i++) begin
        if (writes(r_cmask[i], r_cdest[i])) begin
          ce.p[i] = 1'b1;
          ce.w[6*i +: 6] = tmp[r_cdest[i]];
          tmp[r_cdest[i]] = r_cphys[i];
        end
      end
      mcomm = tmp;
    end
    com_q.push_back(ce);

    re.v = infl_v && !r_rewind; re.d = '0; re.o = '0; re.s = '0;
    if (re.v) begin
      tmp = mspec;
      for (int i = 0; i < 4; i++) begin
        for (int k = 0; k < 2; k++) begin
          re.s[6*(2*i+k) +: 6] = (R0 && infl_src[2*i+k] == 5'd0) ? 6'd0 : tmp[infl_src[2*i+k]];
        end
        if (writes(infl_mask[i], infl_dest[i])) begin
          re.o[6*i +: 6] = tmp[infl_dest[i]];
          re.d[6*i +: 6] = infl_tags[i];
          tmp[infl_dest[i]] = infl_tags[i];
        end
      end
      mspec = tmp;
    end
    ren_q.push_back(re);

    if (r_rewind) mspec = mcomm;

    infl_v = r_rv && !r_rewind;
    if (infl_v) begin
      infl_mask = r_mask;
      for (int i = 0; i < 4; i++) begin
        infl_dest[i] = r_dest[i];
        infl_tags[i] = 6'(32 + (tag_ctr + i) % 32);
      end
      for (int s = 0; s < 8; s++) infl_src[s] = r_src[s];
      tag_ctr += 4;
    end
  endtask

  task automatic idle_inputs();
    r_reset = 1'b1; r_en = 1'b1; r_rewind = 1'b0; r_rv = 1'b0; r_cv = 1'b0;
    r_mask = '0; r_cmask = '0;
    for (int i = 0; i < 4; i++) begin
      r_dest[i] = '0; r_cdest[i] = '0; r_cphys[i] = '0;
    end
    for (int s = 0; s < 8; s++) r_src[s] = '0;
  endtask

  // Applies r_* for one cycle; called at a falling edge, returns at the next one.
  task automatic step();
    reset = r_reset; en = r_en; rewind = r_rewind;
    rename_valid = r_rv; rename_mask = r_mask;
    commit_valid = r_cv; commit_mask = r_cmask;
    for (int i = 0; i < 4; i++) begin
      dest_arch[5*i +: 5]        = r_dest[i];
      commit_dest_arch[5*i +: 5] = r_cdest[i];
      commit_phys[6*i +: 6]      = r_cphys[i];
      new_phys[6*i +: 6]         = infl_v ? infl_tags[i] : 6'($urandom);
    end
    for (int s = 0; s < 8; s++) src_arch[5*s +: 5] = r_src[s];
    if (!r_reset) model_reset();
    else if (r_en) model_cycle();
    #1;
    chk("enable_take", 48'(enable_take), 48'(r_en & r_rv & ~r_rewind));
    chk("take", 48'(take), 48'hF);
    @(negedge clk);
  endtask

  // Monitor: one expectation per enabled edge; reset edges must zero the outputs.
  always @(posedge clk) begin
    logic e_en, e_rst;
    ren_exp_t re;
    com_exp_t ce;
    e_en = en;
    e_rst = reset;
    #1;
    if (!e_rst) begin
      chk("rst_out_valid", 48'(out_valid), 48'd0);
      chk("rst_out_dest", 48'(out_dest_phys), 48'd0);
      chk("rst_enable_put", 48'(enable_put), 48'd0);
      chk("rst_write_put", 48'(write_put), 48'd0);
    end else if (e_en) begin
      if (ren_q.size() == 0 || com_q.size() == 0) begin
        chk("scoreboard_underflow", 48'd1, 48'd0);
      end else begin
        re = ren_q.pop_front();
        ce = com_q.pop_front();
        chk("out_valid", 48'(out_valid), 48'(re.v));
        if (re.v && out_valid) begin
          chk("out_dest_phys", 48'(out_dest_phys), 48'(re.d));
          chk("out_old_phys", 48'(out_old_phys), 48'(re.o));
          chk("out_src_phys", out_src_phys, re.s);
        end
        chk("enable_put", 48'(enable_put), 48'(ce.v));
        if (ce.v && enable_put) begin
          chk("put", 48'(put), 48'(ce.p));
          for (int i = 0; i < 4; i++)
            if (ce.p[i]) chk("write_put", 48'(write_put[6*i +: 6]), 48'(ce.w[6*i +: 6]));
        end
      end
    end
  end

  function automatic logic [4:0] rnd_arch();
    return ($urandom % 2) ? 5'($urandom % 4) : 5'($urandom);
  endfunction

  initial begin
    idle_inputs();
    model_reset();
    r_reset = 1'b0;
    step(); step();
    idle_inputs();
    step();

    // Read r5 from reset map.
    r_rv = 1'b1; r_src[0] = 5'd5; step();
    idle_inputs(); step(); step();

    // Full-mask group r1..r4, then a reader of r3.
    tag_ctr = 0;
    r_rv = 1'b1; r_mask = 4'hF;
    r_dest[0] = 5'd1; r_dest[1] = 5'd2; r_dest[2] = 5'd3; r_dest[3] = 5'd4;
    step();
    idle_inputs(); r_rv = 1'b1; r_src[0] = 5'd3; step();
    idle_inputs(); step(); step();

    // Intra-group bypass on r7 with two writers.
    r_rv = 1'b1; r_mask = 4'b1001; r_dest[0] = 5'd7; r_dest[3] = 5'd7; r_src[4] = 5'd7;
    step();
    idle_inputs(); step(); step();

    // Commit r7 in slot3.
    r_cv = 1'b1; r_cmask = 4'b1000; r_cdest[3] = 5'd7; r_cphys[3] = 6'd43; step();
    idle_inputs(); step();

    // Rename r9, then rewind alongside a commit of r2, then read r9/r2.
    r_rv = 1'b1; r_mask = 4'b0001; r_dest[0] = 5'd9; step();
    idle_inputs(); step();
    r_rv = 1'b1; r_rewind = 1'b1; r_cv = 1'b1; r_cmask = 4'b0001;
    r_cdest[0] = 5'd2; r_cphys[0] = 6'd33; r_mask = 4'b0001; r_dest[0] = 5'd11;
    step();
    idle_inputs(); r_rv = 1'b1; r_src[0] = 5'd9; r_src[1] = 5'd2; step();
    idle_inputs(); step(); step();

    // Dest r0 and src r0.
    r_rv = 1'b1; r_mask = 4'b0001; r_dest[0] = 5'd0; r_src[2] = 5'd0; step();
    idle_inputs(); r_rv = 1'b1; r_src[0] = 5'd0; step();
    idle_inputs(); step(); step();

    // Randomized traffic with stalls, rewinds and one mid-run reset.
    for (int n = 0; n < 1500; n++) begin
      idle_inputs();
      r_reset  = (n != 700);
      r_en     = ($urandom % 10) != 0;
      r_rewind = ($urandom % 12) == 0;
      r_rv     = ($urandom % 4) != 0;
      r_mask   = 4'($urandom);
      r_cv     = ($urandom % 3) == 0;
      r_cmask  = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        r_dest[i]  = rnd_arch();
        r_cdest[i] = rnd_arch();
        r_cphys[i] = 6'($urandom);
      end
      for (int s = 0; s < 8; s++) r_src[s] = rnd_arch();
      step();
    end

    idle_inputs();
    step(); step(); step();
    if (ren_q.size() != 0 || com_q.size() != 0) chk("scoreboard_drain", 48'(ren_q.size()), 48'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
